// File: rtl/pic_cycle_controller.sv
// Single-clock Q-phase sequencer for the PIC datapath: walks each instruction through
// Q1..Q4, issues per-phase enable strobes, handles branch/skip bubbles, hold and a retire count.
module pic_cycle_controller #(
  parameter logic [3:0] OP_NOP  = 4'h0,
  parameter logic [3:0] OP_SKIP = 4'hE,
  parameter logic [3:0] OP_GOTO = 4'hF,
  parameter int         CNT_W   = 16
) (
  input  logic             master_clk,
  input  logic             reset,
  input  logic             hold,
  input  logic [3:0]       opcode,
  input  logic             dest_f,
  input  logic             alu_zero,
  output logic [1:0]       q_phase,
  output logic             ir_load,
  output logic             f_rd,
  output logic             alu_en,
  output logic             w_we,
  output logic             f_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             flush,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_Q1,
    S_Q2,
    S_Q3,
    S_Q4
  } state_t;

  state_t           state, state_nxt;
  logic             flush_q, flush_nxt;
  logic             skip_pend, skip_nxt;
  logic [CNT_W-1:0] retired_q, retired_nxt;

  logic is_goto, writes_back;
  assign is_goto     = (opcode == OP_GOTO);
  assign writes_back = !flush_q && (opcode != OP_NOP) && !is_goto;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; hold simply withholds the enable so nothing advances.
  always_ff @(posedge master_clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      flush_q   <= 1'b0;
      skip_pend <= 1'b0;
      retired_q <= '0;
    end else if (!hold) begin
      state     <= state_nxt;
      flush_q   <= flush_nxt;
      skip_pend <= skip_nxt;
      retired_q <= retired_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    flush_nxt   = flush_q;
    skip_nxt    = skip_pend;
    retired_nxt = retired_q;
    unique case (state)
      S_IDLE: state_nxt = S_Q1;
      S_Q1:   state_nxt = S_Q2;
      S_Q2:   state_nxt = S_Q3;
      S_Q3: begin
        state_nxt = S_Q4;
        skip_nxt  = (opcode == OP_SKIP) && alu_zero && !flush_q;
      end
      S_Q4: begin
        state_nxt = S_Q1;
        // A bubble never spawns another bubble, whatever opcode it carried.
        flush_nxt = skip_pend || (is_goto && !flush_q);
        skip_nxt  = 1'b0;
        if (!flush_q) retired_nxt = retired_q + CNT_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    q_phase = 2'd0;
    ir_load = 1'b0;
    f_rd    = 1'b0;
    alu_en  = 1'b0;
    w_we    = 1'b0;
    f_we    = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    unique case (state)
      S_Q1: q_phase = 2'd0;
      S_Q2: q_phase = 2'd1;
      S_Q3: q_phase = 2'd2;
      S_Q4: q_phase = 2'd3;
      default: q_phase = 2'd0;
    endcase
    if (!hold) begin
      unique case (state)
        S_Q1: ir_load = 1'b1;
        S_Q2: f_rd    = 1'b1;
        S_Q3: alu_en  = 1'b1;
        S_Q4: begin
          pc_inc  = !is_goto || flush_q;
          pc_load = is_goto && !flush_q;
          w_we    = writes_back && !dest_f;
          f_we    = writes_back && dest_f;
        end
        default: ;
      endcase
    end
  end

  assign flush   = flush_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_pic_cycle_controller.sv
// Directed bench for pic_cycle_controller: a per-cycle vector table plus hand sequences
// for mid-instruction reset and counter wrap (second instance with a 4-bit counter).
module tb_pic_cycle_controller;

  logic        master_clk = 1'b0;
  logic        reset;
  logic        hold;
  logic [3:0]  opcode;
  logic        dest_f;
  logic        alu_zero;

  logic [1:0]  q_phase;
  logic        ir_load, f_rd, alu_en, w_we, f_we, pc_inc, pc_load, flush;
  logic [15:0] retired;

  logic [1:0]  n_q_phase;
  logic        n_ir_load, n_f_rd, n_alu_en, n_w_we, n_f_we, n_pc_inc, n_pc_load, n_flush;
  logic [3:0]  n_retired;

  always #5 master_clk = ~master_clk;

  pic_cycle_controller dut (
    .master_clk(master_clk), .reset(reset), .hold(hold), .opcode(opcode),
    .dest_f(dest_f), .alu_zero(alu_zero), .q_phase(q_phase), .ir_load(ir_load),
    .f_rd(f_rd), .alu_en(alu_en), .w_we(w_we), .f_we(f_we), .pc_inc(pc_inc),
    .pc_load(pc_load), .flush(flush), .retired(retired)
  );

  pic_cycle_controller #(.CNT_W(4)) dut_narrow (
    .master_clk(master_clk), .reset(reset), .hold(hold), .opcode(opcode),
    .dest_f(dest_f), .alu_zero(alu_zero), .q_phase(n_q_phase), .ir_load(n_ir_load),
    .f_rd(n_f_rd), .alu_en(n_alu_en), .w_we(n_w_we), .f_we(n_f_we), .pc_inc(n_pc_inc),
    .pc_load(n_pc_load), .flush(n_flush), .retired(n_retired)
  );

  // Strobe vector order: ir_load f_rd alu_en w_we f_we pc_inc pc_load flush
  logic [7:0] strobes, n_strobes;
  assign strobes   = {ir_load, f_rd, alu_en, w_we, f_we, pc_inc, pc_load, flush};
  assign n_strobes = {n_ir_load, n_f_rd, n_alu_en, n_w_we, n_f_we, n_pc_inc, n_pc_load, n_flush};

  typedef struct {
    logic       hold;
    logic [3:0] op;
    logic       dest;
    logic       az;
    logic [1:0] q;
    logic [7:0] s;
    int         ret;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add_row(input logic h, input logic [3:0] op, input logic d, input logic az,
                         input logic [1:0] q, input logic [7:0] s, input int ret);
    vec_t v;
    v.hold = h; v.op = op; v.dest = d; v.az = az; v.q = q; v.s = s; v.ret = ret;
    vecs.push_back(v);
  endtask

  // One instruction = four table rows; q4 is the expected {w_we,f_we,pc_inc,pc_load} at Q4.
  task automatic add_instr(input logic [3:0] op, input logic d, input logic az,
                           input logic fl, input logic [3:0] q4, input int ret,
                           input int n_hold);
    add_row(1'b0, op, d, az, 2'd0, {1'b1, 6'b0, fl}, ret);
    add_row(1'b0, op, d, az, 2'd1, {1'b0, 1'b1, 5'b0, fl}, ret);
    for (int h = 0; h < n_hold; h++) add_row(1'b1, op, d, az, 2'd2, {7'b0, fl}, ret);
    add_row(1'b0, op, d, az, 2'd2, {2'b0, 1'b1, 4'b0, fl}, ret);
    add_row(1'b0, op, d, az, 2'd3, {3'b0, q4, fl}, ret);
  endtask

  task automatic drive(input logic [3:0] op, input logic d, input logic az);
    opcode = op; dest_f = d; alu_zero = az;
  endtask

  initial begin
    reset = 1'b0; hold = 1'b0;
    drive(4'h3, 1'b0, 1'b0);

    // IDLE cycle right after reset release, then the instruction stream.
    add_row(1'b0, 4'h3, 1'b0, 1'b0, 2'd0, 8'h00, 0);
    add_instr(4'h3, 1'b0, 1'b0, 1'b0, 4'b1010, 0, 0);
    add_instr(4'h3, 1'b0, 1'b0, 1'b0, 4'b1010, 1, 0);
    add_instr(4'h3, 1'b0, 1'b0, 1'b0, 4'b1010, 2, 0);
    add_instr(4'hF, 1'b0, 1'b0, 1'b0, 4'b0001, 3, 0);  // GOTO
    add_instr(4'h3, 1'b1, 1'b0, 1'b1, 4'b0010, 4, 0);  // bubble
    add_instr(4'h3, 1'b1, 1'b0, 1'b0, 4'b0110, 4, 0);
    add_instr(4'hE, 1'b0, 1'b1, 1'b0, 4'b1010, 5, 0);  // skip taken
    add_instr(4'h3, 1'b0, 1'b0, 1'b1, 4'b0010, 6, 0);  // skipped
    add_instr(4'hE, 1'b1, 1'b0, 1'b0, 4'b0110, 6, 0);  // skip not taken
    add_instr(4'h3, 1'b0, 1'b0, 1'b0, 4'b1010, 7, 0);
    add_instr(4'hF, 1'b0, 1'b0, 1'b0, 4'b0001, 8, 0);  // GOTO
    add_instr(4'hF, 1'b0, 1'b0, 1'b1, 4'b0010, 9, 0);  // flushed GOTO: no new bubble
    add_instr(4'h0, 1'b1, 1'b0, 1'b0, 4'b0010, 9, 0);  // NOP: no writeback
    add_instr(4'hF, 1'b0, 1'b0, 1'b0, 4'b0001, 10, 0); // GOTO
    add_instr(4'hE, 1'b0, 1'b1, 1'b1, 4'b0010, 11, 0); // flushed SKIP: no new bubble
    add_instr(4'h3, 1'b1, 1'b0, 1'b0, 4'b0110, 11, 0);
    add_instr(4'h3, 1'b0, 1'b0, 1'b0, 4'b1010, 12, 5); // hold entering Q3

    for (int c = 0; c < 3; c++) begin
      @(negedge master_clk);
      drive(4'(c + 13), c[0], 1'b1);
      #1;
      check("rst_q_phase", c, 32'(q_phase), 32'd0);
      check("rst_strobes", c, 32'(strobes), 32'd0);
      check("rst_retired", c, 32'(retired), 32'd0);
    end

    @(negedge master_clk);
    reset = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      hold = vecs[i].hold;
      drive(vecs[i].op, vecs[i].dest, vecs[i].az);
      #1;
      check("q_phase", i, 32'(q_phase), 32'(vecs[i].q));
      check("strobes", i, 32'(strobes), 32'(vecs[i].s));
      check("retired", i, 32'(retired), 32'(vecs[i].ret));
      check("n_strobes", i, 32'(n_strobes), 32'(vecs[i].s));
      check("n_retired", i, 32'(n_retired), 32'(vecs[i].ret % 16));
      @(negedge master_clk);
    end

    // Two more W writes bring the count to 15.
    hold = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(4'h3, 1'b0, 1'b0);
      #1;
      if (k % 4 == 3) check("w_we_pre", k, 32'(w_we), 32'd1);
      @(negedge master_clk);
    end
    #1;
    check("ret_15", 0, 32'(retired), 32'd15);
    check("n_ret_15", 0, 32'(n_retired), 32'd15);

    // Reset asynchronously during Q3 of a W write: the write must never happen.
    @(negedge master_clk);
    @(negedge master_clk);
    #1;
    check("q3_alu_en", 0, 32'(alu_en), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_q_phase", 0, 32'(q_phase), 32'd0);
    check("mid_rst_strobes", 0, 32'(strobes), 32'd0);
    check("mid_rst_retired", 0, 32'(retired), 32'd0);
    check("mid_rst_n_retired", 0, 32'(n_retired), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge master_clk);
      #1;
      check("mid_rst_w_we", c, 32'(w_we), 32'd0);
      check("mid_rst_ret_hold", c, 32'(retired), 32'd0);
    end

    // Fresh run: 16 instructions wrap the 4-bit counter back to 0.
    @(negedge master_clk);
    reset = 1'b1;
    @(negedge master_clk);
    for (int i = 0; i < 16; i++) begin
      #1;
      if (i == 0) check("wrap_start", i, 32'(retired), 32'd0);
      if (i == 15) begin
        check("wrap_pre", i, 32'(retired), 32'd15);
        check("n_wrap_pre", i, 32'(n_retired), 32'hF);
      end
      for (int p = 0; p < 4; p++) @(negedge master_clk);
    end
    #1;
    check("wrap_wide", 0, 32'(retired), 32'd16);
    check("wrap_narrow", 0, 32'(n_retired), 32'd0);
    check("wrap_q_phase", 0, 32'(q_phase), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
